// File: rtl/risc_div_pkg.sv
// risc_div_pkg: shared FSM encoding and two's-complement helper for the sequential divider.
//   STATE_W     : width of the divider state encoding
//   MAX_W       : widest operand the sign helper handles (callers resize to/from it)
//   div_state_t : IDLE / CALC / FIX / DONE
//   cond_neg    : returns -x when en is set, x otherwise (abs value and sign fix-up)
package risc_div_pkg;
    localparam int STATE_W = 2;
    localparam int MAX_W   = 64;

    typedef enum logic [STATE_W-1:0] {IDLE, CALC, FIX, DONE} div_state_t;

    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic en);
        return en ? ~x + 1'b1 : x;
    endfunction
endpackage

// File: rtl/risc_div_step.sv
// risc_div_step: one combinational restoring-division iteration (shift, trial subtract, select).
//   rem_in  : partial remainder before this step
//   dvd_in  : remaining dividend bits, MSB consumed first
//   divisor : magnitude of the divisor
//   rem_out : partial remainder after this step
//   dvd_out : dividend shifted left by one
//   qbit    : quotient bit produced by this step
module risc_div_step
    import risc_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] dvd_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] dvd_out,
    output logic             qbit
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // The shifted remainder is below 2*divisor, so WIDTH+1 bits hold both it and
    // the signed trial difference; the top bit of the trial is its sign.
    assign w_shift = {rem_in, dvd_in[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, divisor};
    assign qbit    = ~w_trial[WIDTH];
    assign rem_out = qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign dvd_out = {dvd_in[WIDTH-2:0], 1'b0};
endmodule

// File: rtl/risc_seq_divider.sv
// risc_seq_divider: multi-cycle radix-2 restoring integer divider, signed or unsigned per request.
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   flush          : synchronous abort of any in-flight operation
//   in_valid/ready : request handshake; in_signed selects two's-complement operands
//   in_dividend, in_divisor, in_tag : request operands and opaque tag
//   out_valid/ready: result handshake
//   out_quotient, out_remainder, out_tag : truncating-division result and returned tag
//   out_dz, out_ovf: divide-by-zero and signed MIN / -1 flags
module risc_seq_divider
    import risc_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dz,
    output logic             out_ovf
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       r_state;
    div_state_t       w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic [TAG_W-1:0] r_tag;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_ovf;

    logic             w_accept;
    logic             w_neg_dvd;
    logic             w_neg_dsr;
    logic             w_dz;
    logic             w_ovf;
    logic [WIDTH-1:0] w_abs_dvd;
    logic [WIDTH-1:0] w_abs_dsr;
    logic [WIDTH-1:0] w_fix_q;
    logic [WIDTH-1:0] w_fix_r;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_dvd;
    logic             w_qbit;

    // A request that coincides with flush is dropped, not accepted.
    assign w_accept  = in_valid & (r_state == IDLE) & ~flush;
    assign w_neg_dvd = in_signed & in_dividend[WIDTH-1];
    assign w_neg_dsr = in_signed & in_divisor[WIDTH-1];
    assign w_dz      = (in_divisor == '0);
    assign w_ovf     = in_signed & (in_dividend == MIN_VAL) & (in_divisor == '1);

    // |MIN| comes out as the unsigned pattern 2^(WIDTH-1), which the unsigned core divides exactly.
    assign w_abs_dvd = WIDTH'(cond_neg(MAX_W'(in_dividend), w_neg_dvd));
    assign w_abs_dsr = WIDTH'(cond_neg(MAX_W'(in_divisor), w_neg_dsr));
    assign w_fix_q   = WIDTH'(cond_neg(MAX_W'(r_quo), r_neg_q));
    assign w_fix_r   = WIDTH'(cond_neg(MAX_W'(r_rem), r_neg_r));

    risc_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (r_rem),
        .dvd_in  (r_dvd),
        .divisor (r_dsr),
        .rem_out (w_step_rem),
        .dvd_out (w_step_dvd),
        .qbit    (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) w_next = w_dz ? DONE : CALC;
            end
            CALC: w_next = (r_cnt == '0) ? FIX : CALC;
            FIX:  w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (flush) w_next = IDLE;
    end

    // Divide-by-zero skips CALC/FIX, so its final quotient and raw dividend are loaded at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dsr   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_tag   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_rem   <= w_dz ? in_dividend : '0;
            r_quo   <= w_dz ? '1 : '0;
            r_dvd   <= w_abs_dvd;
            r_dsr   <= w_abs_dsr;
            r_cnt   <= CNT_W'(WIDTH-1);
            r_tag   <= in_tag;
            r_neg_q <= w_neg_dvd ^ w_neg_dsr;
            r_neg_r <= w_neg_dvd;
            r_dz    <= w_dz;
            r_ovf   <= w_ovf;
        end else if (r_state == CALC) begin
            r_rem   <= w_step_rem;
            r_dvd   <= w_step_dvd;
            r_quo   <= {r_quo[WIDTH-2:0], w_qbit};
            r_cnt   <= r_cnt - 1'b1;
        end else if (r_state == FIX) begin
            r_quo   <= w_fix_q;
            r_rem   <= w_fix_r;
        end
    end

    assign out_quotient  = r_quo;
    assign out_remainder = r_rem;
    assign out_tag       = r_tag;
    assign out_dz        = r_dz;
    assign out_ovf       = r_ovf;
endmodule

// File: tb/tb_risc_seq_divider.sv
// tb_risc_seq_divider: scoreboard bench for a 32-bit and an 8-bit divider instance.
module tb_risc_seq_divider;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  tag;
        logic        dz;
        logic        ovf;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    exp_t sb32[$];
    exp_t sb8[$];

    logic        f32 = 1'b0, iv32 = 1'b0, is32 = 1'b0, or32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0;
    logic [3:0]  t32 = '0;
    logic        ir32, ov32, dz32, ovf32;
    logic [31:0] q32, r32;
    logic [3:0]  ot32;

    logic        f8 = 1'b0, iv8 = 1'b0, is8 = 1'b0, or8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [3:0]  t8 = '0;
    logic        ir8, ov8, dz8, ovf8;
    logic [7:0]  q8, r8;
    logic [3:0]  ot8;
    bit          rand_or8 = 1'b0;

    risc_seq_divider #(.WIDTH(32), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(f32), .in_valid(iv32), .in_ready(ir32),
        .in_signed(is32), .in_dividend(a32), .in_divisor(b32), .in_tag(t32),
        .out_valid(ov32), .out_ready(or32), .out_quotient(q32), .out_remainder(r32),
        .out_tag(ot32), .out_dz(dz32), .out_ovf(ovf32)
    );

    risc_seq_divider #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .flush(f8), .in_valid(iv8), .in_ready(ir8),
        .in_signed(is8), .in_dividend(a8), .in_divisor(b8), .in_tag(t8),
        .out_valid(ov8), .out_ready(or8), .out_quotient(q8), .out_remainder(r8),
        .out_tag(ot8), .out_dz(dz8), .out_ovf(ovf8)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Truncating division on plain integers; divide-by-zero returns all ones and the dividend.
    function automatic exp_t model(input int w, input logic s, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] tag, input int acc);
        exp_t   e;
        longint sa, sb, m;
        m  = (longint'(1) << w) - 1;
        sa = (s && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = (s && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
        e.tag = tag;
        e.acc = acc;
        e.dz  = (sb == 0);
        e.ovf = s && (sa == -(longint'(1) << (w-1))) && (sb == -1);
        if (e.dz) begin
            e.q   = 32'(m);
            e.r   = a;
            e.lat = 1;
        end else begin
            e.q   = 32'((sa / sb) & m);
            e.r   = 32'((sa % sb) & m);
            e.lat = w + 2;
        end
        return e;
    endfunction

    task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag, input bit push);
        int n = 0;
        @(posedge clk); #1;
        is32 = s; a32 = a; b32 = b; t32 = tag; iv32 = 1'b1;
        while (!ir32 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait32", 64'(n < 500), 1);
        if (push) sb32.push_back(model(32, s, a, b, tag, cyc));
        @(posedge clk); #1;
        iv32 = 1'b0; a32 = $urandom; b32 = $urandom; is32 = $urandom_range(0, 1);
    endtask

    task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] tag);
        int n = 0;
        @(posedge clk); #1;
        is8 = s; a8 = a; b8 = b; t8 = tag; iv8 = 1'b1;
        while (!ir8 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait8", 64'(n < 500), 1);
        sb8.push_back(model(8, s, 32'(a), 32'(b), tag, cyc));
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    task automatic drain(input bit w8);
        int n = 0;
        while ((w8 ? sb8.size() : sb32.size()) != 0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check(w8 ? "drain8" : "drain32", 64'(n < 5000), 1);
    endtask

    function automatic logic [7:0] pick8();
        int k = $urandom_range(0, 7);
        return (k == 0) ? 8'h00 : (k == 1) ? 8'h80 : (k == 2) ? 8'hFF : (k == 3) ? 8'h01 : 8'($urandom);
    endfunction

    bit          seen32 = 1'b0;
    int          first32 = 0;
    logic [31:0] hq32, hr32;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) seen32 = 1'b0;
            else if (ov32) begin
                if (!seen32) begin
                    seen32 = 1'b1; first32 = cyc; hq32 = q32; hr32 = r32;
                end else begin
                    check("hold_q32", 64'(q32), 64'(hq32));
                    check("hold_r32", 64'(r32), 64'(hr32));
                end
                check("busy_in_ready32", 64'(ir32), 0);
                if (or32) begin
                    seen32 = 1'b0;
                    check("result_pending32", 64'(sb32.size() != 0), 1);
                    if (sb32.size() != 0) begin
                        e = sb32.pop_front();
                        check("q32", 64'(q32), 64'(e.q));
                        check("r32", 64'(r32), 64'(e.r));
                        check("tag32", 64'(ot32), 64'(e.tag));
                        check("dz32", 64'(dz32), 64'(e.dz));
                        check("ovf32", 64'(ovf32), 64'(e.ovf));
                        check("lat32", 64'(first32 - e.acc), 64'(e.lat));
                    end
                end
            end
        end
    end

    bit seen8 = 1'b0;
    int first8 = 0;
    logic [7:0] hq8, hr8;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) seen8 = 1'b0;
            else if (ov8) begin
                if (!seen8) begin
                    seen8 = 1'b1; first8 = cyc; hq8 = q8; hr8 = r8;
                end else begin
                    check("hold_q8", 64'(q8), 64'(hq8));
                    check("hold_r8", 64'(r8), 64'(hr8));
                end
                if (or8) begin
                    seen8 = 1'b0;
                    check("result_pending8", 64'(sb8.size() != 0), 1);
                    if (sb8.size() != 0) begin
                        e = sb8.pop_front();
                        check("q8", 64'(q8), 64'(e.q));
                        check("r8", 64'(r8), 64'(e.r));
                        check("tag8", 64'(ot8), 64'(e.tag));
                        check("dz8", 64'(dz8), 64'(e.dz));
                        check("ovf8", 64'(ovf8), 64'(e.ovf));
                        check("lat8", 64'(first8 - e.acc), 64'(e.lat));
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_or8) or8 = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit any;
        int n;
        repeat (3) @(negedge clk);
        check("rst_in_ready32", 64'(ir32), 1);
        check("rst_out_valid32", 64'(ov32), 0);
        check("rst_q32", 64'(q32), 0);
        check("rst_r32", 64'(r32), 0);
        check("rst_tag32", 64'(ot32), 0);
        check("rst_flags32", 64'({dz32, ovf32}), 0);
        check("rst_in_ready8", 64'(ir8), 1);
        check("rst_out_valid8", 64'(ov8), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        issue32(1'b0, 32'd100, 32'd7, 4'd5, 1'b1);
        drain(1'b0);
        issue32(1'b1, -32'sd7, 32'd2, 4'd1, 1'b1);
        issue32(1'b1, 32'd7, -32'sd2, 4'd2, 1'b1);
        issue32(1'b0, 32'hFFFF_FFF9, 32'd2, 4'd3, 1'b1);
        issue32(1'b1, 32'd55, 32'd0, 4'd4, 1'b1);
        issue32(1'b0, 32'd55, 32'd0, 4'd6, 1'b1);
        issue32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 1'b1);
        issue32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 1'b1);
        issue32(1'b1, -32'sd1000, -32'sd7, 4'd9, 1'b1);
        drain(1'b0);

        or32 = 1'b0;
        issue32(1'b0, 32'd1000, 32'd3, 4'd10, 1'b1);
        n = 0;
        while (!ov32 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid", 64'(ov32), 1);
        iv32 = 1'b1; a32 = 32'd9; b32 = 32'd1; t32 = 4'd11;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_in_ready", 64'(ir32), 0);
            check("bp_out_valid", 64'(ov32), 1);
        end
        iv32 = 1'b0; or32 = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", 64'(ir32), 1);
        check("bp_out_valid_after", 64'(ov32), 0);
        check("bp_scoreboard_empty", 64'(sb32.size()), 0);

        issue32(1'b0, 32'd12345, 32'd7, 4'd12, 1'b0);
        repeat (9) @(posedge clk);
        #1 f32 = 1'b1;
        @(posedge clk); #1 f32 = 1'b0;
        check("flush_in_ready", 64'(ir32), 1);
        iv32 = 1'b1; f32 = 1'b1; a32 = 32'd50; b32 = 32'd0;
        @(posedge clk); #1 iv32 = 1'b0; f32 = 1'b0;
        any = 1'b0;
        repeat (50) begin
            @(negedge clk);
            any |= ov32;
        end
        check("flush_no_result", 64'(any), 0);

        issue32(1'b1, -32'sd500, 32'd3, 4'd13, 1'b0);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(ir32), 1);
        check("midrst_out_valid", 64'(ov32), 0);
        check("midrst_q", 64'(q32), 0);
        check("midrst_r", 64'(r32), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        any = 1'b0;
        repeat (50) begin
            @(negedge clk);
            any |= ov32;
        end
        check("midrst_no_result", 64'(any), 0);

        issue32(1'b0, 32'd1000, 32'd10, 4'd14, 1'b1);
        drain(1'b0);
        for (int i = 0; i < 40; i++)
            issue32(1'($urandom), $urandom, (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom, 4'(i), 1'b1);
        drain(1'b0);

        rand_or8 = 1'b1;
        for (int i = 0; i < 2000; i++)
            issue8(1'($urandom), pick8(), pick8(), 4'(i));
        drain(1'b1);
        rand_or8 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
